// File: rtl/mem_pool_pkg.sv
// Shared constants and types for the memory-pool read path.
// Client ids, bank-group read latency and the in-flight read tag.
package mem_pool_pkg;

  localparam int CLIENT_CONV      = 0;
  localparam int CLIENT_DSAVER    = 1;
  localparam int CLIENT_MISC      = 2;
  localparam int CLIENT_NUM       = 3;
  localparam int MEM_READ_LATENCY = 2;

  typedef struct packed {
    logic       valid;
    logic [1:0] client_id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with a one-hot grant.
// The pointer names the highest-priority requester and moves past each winner.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_p,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               idx;

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        if (advance_i) ptr_d = PTR_W'((idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_pool_read_arbiter.sv
// Per-bank round-robin sharing of a bank group's read ports between clients.
// Tracks each issued read through the fixed latency and routes data back.
module mem_pool_read_arbiter
  import mem_pool_pkg::rd_tag_t;
#(
  parameter int BANK_NUM         = 4,
  parameter int BANK_ADDR_WIDTH  = 12,
  parameter int BANK_DATA_WIDTH  = 64,
  parameter int CLIENT_NUM       = mem_pool_pkg::CLIENT_NUM,
  parameter int MEM_READ_LATENCY = mem_pool_pkg::MEM_READ_LATENCY,
  localparam int BANK_SEL_W      = $clog2(BANK_NUM)
) (
  input  logic                                  clk,
  input  logic                                  rst_p,
  input  logic [CLIENT_NUM-1:0]                 cl_req_valid_i,
  input  logic [CLIENT_NUM*BANK_SEL_W-1:0]      cl_req_bank_i,
  input  logic [CLIENT_NUM*BANK_ADDR_WIDTH-1:0] cl_req_addr_i,
  output logic [CLIENT_NUM-1:0]                 cl_req_ready_o,
  output logic [CLIENT_NUM-1:0]                 cl_rsp_valid_o,
  output logic [CLIENT_NUM*BANK_DATA_WIDTH-1:0] cl_rsp_data_o,
  output logic [BANK_NUM-1:0]                   read_bank_en_o,
  output logic [BANK_NUM*BANK_ADDR_WIDTH-1:0]   read_addr_o,
  input  logic [BANK_NUM*BANK_DATA_WIDTH-1:0]   read_data_i
);

  localparam int TAG_STAGES = MEM_READ_LATENCY + 1;

  logic [CLIENT_NUM-1:0]      bank_req [BANK_NUM];
  logic [CLIENT_NUM-1:0]      bank_gnt [BANK_NUM];
  logic [BANK_ADDR_WIDTH-1:0] addr_q   [BANK_NUM];
  logic [BANK_ADDR_WIDTH-1:0] addr_d   [BANK_NUM];
  rd_tag_t                    tag_q    [BANK_NUM][TAG_STAGES];
  rd_tag_t                    tag_d    [BANK_NUM][TAG_STAGES];

  always_comb begin
    for (int b = 0; b < BANK_NUM; b++) begin
      for (int c = 0; c < CLIENT_NUM; c++) begin
        bank_req[b][c] = cl_req_valid_i[c] &&
                         (cl_req_bank_i[c*BANK_SEL_W +: BANK_SEL_W] == BANK_SEL_W'(b));
      end
    end
  end

  generate
    for (genvar gi = 0; gi < BANK_NUM; gi++) begin : g_bank_arb
      rr_arbiter #(.N(CLIENT_NUM)) u_arb (
        .clk       (clk),
        .rst_p     (rst_p),
        .req_i     (bank_req[gi]),
        .advance_i (|bank_req[gi]),
        .grant_o   (bank_gnt[gi])
      );
    end
  endgenerate

  // Each client targets one bank, so OR-ing the per-bank grants is exact.
  always_comb begin
    cl_req_ready_o = '0;
    for (int b = 0; b < BANK_NUM; b++) cl_req_ready_o |= bank_gnt[b];
  end

  // Stage 0 of the tag pipe doubles as the issue-valid register.
  always_comb begin
    for (int b = 0; b < BANK_NUM; b++) begin
      addr_d[b]   = addr_q[b];
      tag_d[b][0] = '0;
      for (int c = 0; c < CLIENT_NUM; c++) begin
        if (bank_gnt[b][c]) begin
          addr_d[b]             = cl_req_addr_i[c*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH];
          tag_d[b][0].valid     = 1'b1;
          tag_d[b][0].client_id = 2'(c);
        end
      end
      for (int s = 1; s < TAG_STAGES; s++) tag_d[b][s] = tag_q[b][s-1];
    end
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      for (int b = 0; b < BANK_NUM; b++) begin
        addr_q[b] <= '0;
        for (int s = 0; s < TAG_STAGES; s++) tag_q[b][s] <= '0;
      end
    end else begin
      addr_q <= addr_d;
      tag_q  <= tag_d;
    end
  end

  always_comb begin
    read_bank_en_o = '0;
    read_addr_o    = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      read_bank_en_o[b]                                 = tag_q[b][0].valid;
      read_addr_o[b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] = addr_q[b];
    end
  end

  int cid;

  always_comb begin
    cl_rsp_valid_o = '0;
    cl_rsp_data_o  = '0;
    cid            = 0;
    for (int b = 0; b < BANK_NUM; b++) begin
      cid = int'(tag_q[b][TAG_STAGES-1].client_id);
      if (tag_q[b][TAG_STAGES-1].valid && cid < CLIENT_NUM) begin
        cl_rsp_valid_o[cid]                                 = 1'b1;
        cl_rsp_data_o[cid*BANK_DATA_WIDTH +: BANK_DATA_WIDTH] =
          read_data_i[b*BANK_DATA_WIDTH +: BANK_DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_mem_pool_read_arbiter.sv
// Scoreboard bench for mem_pool_read_arbiter with a 2-cycle bank-group model.
// Stimulus pushes expected responses; an independent monitor pops and compares.
module tb_mem_pool_read_arbiter;

  localparam int BN = 4;
  localparam int AW = 12;
  localparam int DW = 64;
  localparam int CN = 3;

  logic             clk = 1'b0;
  logic             rst_p;
  logic [CN-1:0]    cl_req_valid_i;
  logic [CN*2-1:0]  cl_req_bank_i;
  logic [CN*AW-1:0] cl_req_addr_i;
  logic [CN-1:0]    cl_req_ready_o;
  logic [CN-1:0]    cl_rsp_valid_o;
  logic [CN*DW-1:0] cl_rsp_data_o;
  logic [BN-1:0]    read_bank_en_o;
  logic [BN*AW-1:0] read_addr_o;
  logic [BN*DW-1:0] read_data_i;

  mem_pool_read_arbiter dut (
    .clk            (clk),
    .rst_p          (rst_p),
    .cl_req_valid_i (cl_req_valid_i),
    .cl_req_bank_i  (cl_req_bank_i),
    .cl_req_addr_i  (cl_req_addr_i),
    .cl_req_ready_o (cl_req_ready_o),
    .cl_rsp_valid_o (cl_rsp_valid_o),
    .cl_rsp_data_o  (cl_rsp_data_o),
    .read_bank_en_o (read_bank_en_o),
    .read_addr_o    (read_addr_o),
    .read_data_i    (read_data_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          exp_q [CN][$];
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  logic [BN-1:0] exp_en   = '0;
  logic [AW-1:0] exp_addr [BN];

  function automatic logic [DW-1:0] mem_word(input int b, input logic [AW-1:0] a);
    if (b == 2 && a == 12'h05A) return 64'hDEADBEEF_00000001;
    return {24'hC0FFEE, 8'(b), 20'h0, a};
  endfunction

  // Bank-group model: data appears MEM_READ_LATENCY cycles after the enable.
  logic [DW-1:0] pipe1 [BN];
  logic [DW-1:0] pipe2 [BN];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int b = 0; b < BN; b++) begin
      pipe1[b] <= read_bank_en_o[b] ? mem_word(b, read_addr_o[b*AW +: AW]) : '0;
      pipe2[b] <= pipe1[b];
    end
  end
  always_comb begin
    for (int b = 0; b < BN; b++) read_data_i[b*DW +: DW] = pipe2[b];
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response strobe is seen.
  always @(negedge clk) begin
    if (rst_p !== 1'b1) begin
      for (int c = 0; c < CN; c++) begin
        if (cl_rsp_valid_o[c]) begin
          if (exp_q[c].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected client=%0d cycle=%0d actual=%h required=none",
                     c, cyc, cl_rsp_data_o[c*DW +: DW]);
          end else begin
            exp_t e;
            e = exp_q[c].pop_front();
            check($sformatf("rsp_data_c%0d", c), cl_rsp_data_o[c*DW +: DW], e.data);
            check($sformatf("rsp_cycle_c%0d", c), 64'(cyc), 64'(e.due));
            $display("rsp client=%0d cycle=%0d data=%h", c, cyc, cl_rsp_data_o[c*DW +: DW]);
          end
        end else begin
          check($sformatf("rsp_zero_c%0d", c), cl_rsp_data_o[c*DW +: DW], 64'd0);
        end
      end
    end
  end

  task automatic do_cycle(input logic [CN-1:0] v, input logic [CN*2-1:0] bk,
                          input logic [CN*AW-1:0] ad, input logic [CN-1:0] exp_rdy,
                          input string nm);
    int b;
    @(posedge clk);
    #1;
    cl_req_valid_i = v;
    cl_req_bank_i  = bk;
    cl_req_addr_i  = ad;
    @(negedge clk);
    check({nm, "_bank_en"}, 64'(read_bank_en_o), 64'(exp_en));
    for (int i = 0; i < BN; i++)
      if (exp_en[i]) check({nm, "_addr"}, 64'(read_addr_o[i*AW +: AW]), 64'(exp_addr[i]));
    check({nm, "_ready"}, 64'(cl_req_ready_o), 64'(exp_rdy));
    $display("req %s cycle=%0d valid=%b ready=%b bank_en=%b", nm, cyc, v, cl_req_ready_o,
             read_bank_en_o);
    exp_en = '0;
    for (int c = 0; c < CN; c++) begin
      if (exp_rdy[c]) begin
        exp_t e;
        b           = int'(bk[c*2 +: 2]);
        exp_en[b]   = 1'b1;
        exp_addr[b] = ad[c*AW +: AW];
        e.data      = mem_word(b, ad[c*AW +: AW]);
        e.due       = cyc + 3;
        exp_q[c].push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle('0, '0, '0, '0, "idle");
  endtask

  task automatic check_reset_outputs(input string nm);
    @(negedge clk);
    check({nm, "_bank_en"}, 64'(read_bank_en_o), 64'd0);
    check({nm, "_addr"}, 64'(read_addr_o), 64'd0);
    check({nm, "_rsp_valid"}, 64'(cl_rsp_valid_o), 64'd0);
    check({nm, "_rsp_data_nz"}, 64'(|cl_rsp_data_o), 64'd0);
    check({nm, "_ready"}, 64'(cl_req_ready_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_p          = 1'b1;
    cl_req_valid_i = '0;
    cl_req_bank_i  = '0;
    cl_req_addr_i  = '0;
    repeat (2) @(posedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_p = 1'b0;

    // Single read: client 1, bank 2, addr 0x05A.
    do_cycle(3'b010, 6'b00_10_00, {12'h000, 12'h05A, 12'h000}, 3'b010, "single");
    idle(4);

    // Contention: all clients on bank 0, expect 0,1,2,0,1,2.
    for (int i = 0; i < 6; i++) begin
      logic [CN-1:0] er;
      er = 3'b001 << (i % 3);
      do_cycle(3'b111, 6'b00_00_00, {12'h300 + 12'(i), 12'h200 + 12'(i), 12'h100 + 12'(i)},
               er, "contend");
    end
    idle(4);

    // Parallel banks: clients 0/1/2 on banks 0/1/3.
    do_cycle(3'b111, 6'b11_01_00, {12'h0C3, 12'h0B1, 12'h0A0}, 3'b111, "parallel");
    check("parallel_en_vec", 64'(exp_en), 64'(4'b1011));
    idle(4);

    // Streaming: client 2, bank 3, addr 0..15 back to back.
    for (int a = 0; a < 16; a++)
      do_cycle(3'b100, 6'b11_00_00, {12'(a), 24'd0}, 3'b100, "stream");
    idle(4);

    // Reset mid-flight: two reads by client 1 on bank 2 leave its pointer at 2.
    do_cycle(3'b010, 6'b00_10_00, {12'h000, 12'h007, 12'h000}, 3'b010, "preflush");
    do_cycle(3'b010, 6'b00_10_00, {12'h000, 12'h008, 12'h000}, 3'b010, "preflush");
    @(posedge clk);
    #1;
    rst_p          = 1'b1;
    cl_req_valid_i = '0;
    for (int c = 0; c < CN; c++) exp_q[c].delete();
    exp_en = '0;
    for (int i = 0; i < 3; i++) begin
      check_reset_outputs("midreset");
      @(posedge clk);
    end
    #1 rst_p = 1'b0;
    do_cycle(3'b111, 6'b10_10_10, {12'h023, 12'h022, 12'h021}, 3'b001, "post_reset");
    do_cycle(3'b111, 6'b10_10_10, {12'h023, 12'h022, 12'h021}, 3'b010, "post_reset");
    idle(5);

    for (int c = 0; c < CN; c++)
      check($sformatf("drain_c%0d", c), 64'(exp_q[c].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
